// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
// Sequencer for an LED group mapper. It steps a 3-bit position once every
// TICK_DIV clock cycles while running and holds a 4-bit pattern nibble beside
// it. A three-state FSM (IDLE / RUN / HOLD) decides when the position moves,
// freezes or clears. Every output comes straight from a flop.
//
// Parameters
//   TICK_DIV  clock cycles per position step (1..65535)
//
// Ports
//   clk      in   system clock; all state changes on its rising edge
//   rst      in   asynchronous active-high reset
//   start    in   run request (IDLE->RUN, HOLD->RUN); ignored while stop is high
//   stop     in   hold request in RUN, clear request in HOLD
//   dir      in   step direction: 0 = increment, 1 = decrement
//   load     in   capture patt_in into the pattern register
//   patt_in  in   new pattern nibble
//   pos      out  position select (registered)
//   patt     out  pattern nibble (registered)
//   busy     out  high exactly while the FSM is in RUN (registered)
//   wrap     out  one-cycle pulse following a 7->0 or 0->7 step (registered)
// -----------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] patt_in,
    output logic [2:0] pos,
    output logic [3:0] patt,
    output logic       busy,
    output logic       wrap
);

    // The counter is at least one bit wide, so TICK_DIV=1 leaves it stuck at 0
    // and every RUN cycle becomes a step cycle.
    localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_pos;
    logic [2:0]    w_pos_nxt;
    logic [3:0]    r_patt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_wrap;
    logic          w_wrap_nxt;
    logic          w_step;

    // A step happens on the last count of an interval while running.
    assign w_step = (r_state == ST_RUN) && (r_cnt == C_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; stop outranks start in every state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                // Unused encoding: fall back to the safe idle state.
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the counter, position, wrap pulse and busy.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_pos_nxt  = r_pos;
        w_wrap_nxt = 1'b0;
        w_busy_nxt = (w_state_nxt == ST_RUN);
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = {CW{1'b0}};
                w_pos_nxt = 3'd0;
            end
            ST_RUN: begin
                if (w_step) begin
                    // The step still lands when stop arrives on the step cycle.
                    w_cnt_nxt = {CW{1'b0}};
                    if (dir) begin
                        w_pos_nxt  = r_pos - 3'd1;
                        w_wrap_nxt = (r_pos == 3'd0);
                    end else begin
                        w_pos_nxt  = r_pos + 3'd1;
                        w_wrap_nxt = (r_pos == 3'd7);
                    end
                end else if (stop) begin
                    // Freeze mid-interval so a resume finishes the same interval.
                    w_cnt_nxt = r_cnt;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1'b1);
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    w_cnt_nxt = {CW{1'b0}};
                    w_pos_nxt = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt;
                    w_pos_nxt = r_pos;
                end
            end
            default: begin
                w_cnt_nxt = {CW{1'b0}};
                w_pos_nxt = 3'd0;
            end
        endcase
    end

    // Datapath registers: tick counter, position, busy flag and wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= {CW{1'b0}};
            r_pos  <= 3'd0;
            r_busy <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pos  <= w_pos_nxt;
            r_busy <= w_busy_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    // Pattern register: changed only by load, never by FSM activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_patt <= 4'h0;
        end else if (load) begin
            r_patt <= patt_in;
        end else begin
            r_patt <= r_patt;
        end
    end

    assign pos  = r_pos;
    assign patt = r_patt;
    assign busy = r_busy;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
// Directed bench for led_seq_ctrl. u_dut4 uses TICK_DIV=4 and u_dut1 uses
// TICK_DIV=1. Both share clk and rst and have separate control inputs.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;

    logic       clk;
    logic       rst;

    logic       start4, stop4, dir4, load4;
    logic [3:0] patt_in4;
    logic [2:0] pos4;
    logic [3:0] patt4;
    logic       busy4, wrap4;

    logic       start1, stop1, dir1, load1;
    logic [3:0] patt_in1;
    logic [2:0] pos1;
    logic [3:0] patt1;
    logic       busy1, wrap1;

    int n_cmp;
    int n_err;

    logic [2:0] exp_pos;
    logic       exp_wrap;

    led_seq_ctrl #(.TICK_DIV(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .stop    (stop4),
        .dir     (dir4),
        .load    (load4),
        .patt_in (patt_in4),
        .pos     (pos4),
        .patt    (patt4),
        .busy    (busy4),
        .wrap    (wrap4)
    );

    led_seq_ctrl #(.TICK_DIV(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .stop    (stop1),
        .dir     (dir1),
        .load    (load1),
        .patt_in (patt_in1),
        .pos     (pos1),
        .patt    (patt1),
        .busy    (busy1),
        .wrap    (wrap1)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        start4 = 1'b0; stop4 = 1'b0; dir4 = 1'b0; load4 = 1'b0; patt_in4 = 4'h0;
        start1 = 1'b0; stop1 = 1'b0; dir1 = 1'b0; load1 = 1'b0; patt_in1 = 4'h0;

        // Reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst0_pos",  {5'd0, pos4},  8'h00);
        check("rst0_patt", {4'd0, patt4}, 8'h00);
        check("rst0_busy", {7'd0, busy4}, 8'h00);
        check("rst0_wrap", {7'd0, wrap4}, 8'h00);
        tick;
        tick;
        rst = 1'b0;

        // Reset mid-interval with a loaded pattern and a non-zero position.
        load4 = 1'b1; patt_in4 = 4'hA;
        tick;
        load4 = 1'b0;
        check("load_A", {4'd0, patt4}, 8'h0A);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        check("run_busy", {7'd0, busy4}, 8'h01);
        tick; tick; tick; tick;
        check("first_step", {5'd0, pos4}, 8'h01);
        tick; tick;
        rst = 1'b1;
        #1;
        check("rstmid_pos",  {5'd0, pos4},  8'h00);
        check("rstmid_patt", {4'd0, patt4}, 8'h00);
        check("rstmid_busy", {7'd0, busy4}, 8'h00);
        check("rstmid_wrap", {7'd0, wrap4}, 8'h00);
        tick;
        rst = 1'b0;
        tick; tick; tick;
        check("post_rst_idle_busy", {7'd0, busy4}, 8'h00);
        check("post_rst_idle_pos",  {5'd0, pos4},  8'h00);

        // Up-count through a full wrap with pattern 9.
        load4 = 1'b1; patt_in4 = 4'h9; dir4 = 1'b0;
        tick;
        load4 = 1'b0;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        check("up_start_busy", {7'd0, busy4}, 8'h01);
        check("up_start_pos",  {5'd0, pos4},  8'h00);
        exp_pos = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                exp_wrap = 1'b0;
                if (c == 3) begin
                    exp_pos  = exp_pos + 3'd1;
                    exp_wrap = (exp_pos == 3'd0);
                end
                check("up_pos",  {5'd0, pos4},  {5'd0, exp_pos});
                check("up_wrap", {7'd0, wrap4}, {7'd0, exp_wrap});
                check("up_patt", {4'd0, patt4}, 8'h09);
            end
        end

        // Down-count from 0: first step gives 7 with a wrap pulse.
        dir4 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                exp_wrap = 1'b0;
                if (c == 3) begin
                    exp_pos  = exp_pos - 3'd1;
                    exp_wrap = (exp_pos == 3'd7);
                end
                check("dn_pos",  {5'd0, pos4},  {5'd0, exp_pos});
                check("dn_wrap", {7'd0, wrap4}, {7'd0, exp_wrap});
            end
        end

        // Hold two cycles into an interval, resume ten cycles later.
        tick; tick;
        stop4 = 1'b1;
        tick;
        stop4 = 1'b0;
        check("hold_busy", {7'd0, busy4}, 8'h00);
        check("hold_pos",  {5'd0, pos4},  8'h05);
        for (int i = 0; i < 10; i++) begin
            tick;
        end
        check("hold_long_pos",  {5'd0, pos4},  8'h05);
        check("hold_long_busy", {7'd0, busy4}, 8'h00);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        check("resume_busy", {7'd0, busy4}, 8'h01);
        tick;
        check("resume_1_pos", {5'd0, pos4}, 8'h05);
        tick;
        check("resume_2_pos", {5'd0, pos4}, 8'h04);

        // Stop on a step cycle: the step still happens before HOLD.
        tick; tick; tick;
        check("pre_stopstep_pos", {5'd0, pos4}, 8'h04);
        stop4 = 1'b1;
        tick;
        stop4 = 1'b0;
        check("stopstep_pos",  {5'd0, pos4},  8'h03);
        check("stopstep_busy", {7'd0, busy4}, 8'h00);

        // Resume, freeze with the counter at 1, then clear with start+stop.
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tick;
        stop4 = 1'b1;
        tick;
        check("hold2_pos",  {5'd0, pos4},  8'h03);
        check("hold2_busy", {7'd0, busy4}, 8'h00);
        start4 = 1'b1;
        tick;
        check("clear_pos",  {5'd0, pos4},  8'h00);
        check("clear_busy", {7'd0, busy4}, 8'h00);
        tick; tick;
        check("idle_prio_busy", {7'd0, busy4}, 8'h00);
        check("idle_prio_pos",  {5'd0, pos4},  8'h00);
        check("clear_patt",     {4'd0, patt4}, 8'h09);
        start4 = 1'b0; stop4 = 1'b0;

        // Restart after the clear: full four-cycle interval, dir=1 -> 7 with wrap.
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        check("restart_busy", {7'd0, busy4}, 8'h01);
        tick; tick; tick;
        check("restart_3_pos", {5'd0, pos4}, 8'h00);
        tick;
        check("restart_4_pos",  {5'd0, pos4},  8'h07);
        check("restart_4_wrap", {7'd0, wrap4}, 8'h01);
        tick;
        check("restart_5_wrap", {7'd0, wrap4}, 8'h00);

        // TICK_DIV=1: a step every cycle, wrap every 8th, load mid-run.
        dir1 = 1'b0;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        check("d1_busy", {7'd0, busy1}, 8'h01);
        check("d1_pos0", {5'd0, pos1},  8'h00);
        exp_pos = 3'd0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            exp_pos  = exp_pos + 3'd1;
            exp_wrap = (exp_pos == 3'd0);
            check("d1_pos",  {5'd0, pos1},  {5'd0, exp_pos});
            check("d1_wrap", {7'd0, wrap1}, {7'd0, exp_wrap});
            if (k == 4) begin
                check("d1_patt_before", {4'd0, patt1}, 8'h00);
                load1 = 1'b1; patt_in1 = 4'h3;
            end
            if (k == 5) begin
                check("d1_patt_after", {4'd0, patt1}, 8'h03);
                load1 = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 4, clock cycles per position step; legal range 1..65535.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port start  input  1  level-sampled request to run or resume.
REQ-005 SHALL provide port stop  input  1  level-sampled request to hold, or to clear when already holding.
REQ-006 SHALL provide port dir  input  1  step direction: 0 = pos increments, 1 = pos decrements.
REQ-007 SHALL provide port load  input  1  capture patt_in into the pattern register.
REQ-008 SHALL provide port patt_in  input  4  new LED pattern nibble.
REQ-009 SHALL provide port pos  output  3  position select for the LED group mapper, registered.
REQ-010 SHALL provide port patt  output  4  pattern nibble for the LED group mapper, registered.
REQ-011 SHALL provide port busy  output  1  high exactly while in state RUN.
REQ-012 SHALL provide port wrap  output  1  one-cycle pulse on position wrap-around.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, HOLD.
REQ-014 SHALL keep an internal tick counter, width ceil(log2(TICK_DIV)), minimum 1 bit, counting 0..TICK_DIV-1.
REQ-015 IDLE: pos = 0, counter = 0; start=1 and stop=0 -> RUN next cycle.
REQ-016 RUN: counter increments each cycle; at TICK_DIV-1 it returns to 0 and pos steps by one per dir in the same cycle.
REQ-017 TICK_DIV=1: pos steps every cycle while in RUN.
REQ-018 pos arithmetic SHALL be modulo 8: up 7->0, down 0->7.
REQ-019 wrap SHALL be 1 for exactly the cycle after a 7->0 (dir=0) or 0->7 (dir=1) step, else 0.
REQ-020 dir SHALL be sampled on the step cycle only; a change mid-interval affects only the next step.
REQ-021 RUN: stop=1 -> HOLD next cycle; pos and counter freeze at their current values; start is ignored while in RUN.
REQ-022 If stop asserts on a step cycle, the step SHALL still occur before entering HOLD.
REQ-023 HOLD: start=1 and stop=0 -> RUN, resuming from the frozen counter value (no restart of the interval).
REQ-024 HOLD: stop=1 -> IDLE; pos and counter clear to 0.
REQ-025 start and stop both high SHALL be treated as stop in every state.
REQ-026 load=1 SHALL update patt to patt_in on the next edge in any state, independent of FSM activity.
REQ-027 patt SHALL NOT be altered by FSM transitions, including HOLD->IDLE.
REQ-028 busy SHALL be derived from the registered state with no combinational path from inputs.
REQ-029 All outputs SHALL be glitch-free registered signals suitable for direct connection to the LED group mapper.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, pos=0, patt=0, counter=0, busy=0, wrap=0, regardless of clk.
REQ-031 Reset asserted mid-RUN SHALL abandon the partial interval; after release the block stays in IDLE until start.
REQ-032 The first edge after rst deasserts SHALL obey normal IDLE rules (start sampled on that edge).

Verification (TICK_DIV=4 unless stated)
REQ-033 Reset: load patt_in=4'hA, start RUN, assert rst mid-interval -> pos=0, patt=0, busy=0, wrap=0 without waiting for clk.
REQ-034 Up-count: load 4'h9, start, dir=0 -> pos 0,1,..,7,0 with one step per 4 cycles; wrap=1 for one cycle after 7->0; patt=9 throughout.
REQ-035 Down-count: dir=1 from pos=0 -> first step gives pos=7 with wrap pulse, then 6,5,...
REQ-036 Hold/resume: stop 2 cycles into an interval -> pos frozen, busy=0; start 10 cycles later -> next step exactly 2 cycles after resume.
REQ-037 Clear and priority: in HOLD assert start and stop together -> IDLE, pos=0; in IDLE start+stop together -> remains IDLE.
REQ-038 TICK_DIV=1: start, dir=0 -> pos increments every cycle, wrap every 8th cycle; load 4'h3 mid-run -> patt=3 next cycle with no pos disturbance.
